// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the 101 detectors: takes words over valid/ready and
// shifts them out one bit per clock on x_o, reloading back-to-back with no gap cycle.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              is_last;
  logic              accept;

  assign is_last = (bit_cnt_q == LastIdx);
  assign accept  = din_valid_i & din_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (is_last && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A load on the last-bit edge overrides the shift, which is what removes the gap cycle.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
      shreg_d   = din_i;
      bit_cnt_d = '0;
    end else if (state_q == StShift && !is_last) begin
      shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      bit_cnt_d = bit_cnt_q + CntW'(1);
    end
  end

  always_comb begin
    x_valid_o   = (state_q == StShift);
    busy_o      = x_valid_o;
    last_o      = x_valid_o & is_last;
    din_ready_o = ~reset_i & ((state_q == StIdle) | is_last);
    x_o         = x_valid_o ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_BIT;
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: two configurations driven at once and compared every cycle
// against a queue-of-pending-bits model, plus literal bit-stream expectations.
module tb_serial_bit_feeder;

  logic       clk;
  logic       rst;
  logic [7:0] din0;
  logic       dv0, rdy0, x0, xv0, last0, busy0;
  logic [3:0] din1;
  logic       dv1, rdy1, x1, xv1, last1, busy1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  bit q0[$];
  bit q1[$];

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .din_i(din0), .din_valid_i(dv0), .din_ready_o(rdy0),
    .x_o(x0), .x_valid_o(xv0), .last_o(last0), .busy_o(busy0)
  );

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .din_i(din1), .din_valid_i(dv1), .din_ready_o(rdy1),
    .x_o(x1), .x_valid_o(xv1), .last_o(last1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted word becomes WIDTH pending bits; one bit is consumed per clock.
  always @(posedge clk) begin
    bit acc0, acc1;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      acc0 = dv0 && (q0.size() <= 1);
      acc1 = dv1 && (q1.size() <= 1);
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (acc0) for (int i = 7; i >= 0; i--) q0.push_back(din0[i]);
      if (acc1) for (int i = 0; i < 4; i++) q1.push_back(din1[i]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("xv0",   xv0,   q0.size() > 0);
      chk("busy0", busy0, q0.size() > 0);
      chk("x0",    x0,    (q0.size() > 0) ? q0[0] : 1'b0);
      chk("last0", last0, q0.size() == 1);
      chk("rdy0",  rdy0,  !rst && (q0.size() <= 1));
      chk("xv1",   xv1,   q1.size() > 0);
      chk("busy1", busy1, q1.size() > 0);
      chk("x1",    x1,    (q1.size() > 0) ? q1[0] : 1'b1);
      chk("last1", last1, q1.size() == 1);
      chk("rdy1",  rdy1,  !rst && (q1.size() <= 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp0;
    logic [7:0] exp1;
    rst = 1'b1; dv0 = 1'b0; dv1 = 1'b0; din0 = '0; din1 = '0;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;

    // Idle after reset: x at idle level, ready high.
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("idle_x0", x0, 1'b0);
    chk("idle_x1", x1, 1'b1);
    chk("idle_rdy0", rdy0, 1'b1);

    // 8'hB5 MSB first and 4'b0011 LSB first, both valid for one clock.
    @(posedge clk); #1;
    din0 = 8'hB5; dv0 = 1'b1; din1 = 4'b0011; dv1 = 1'b1;
    tick();
    dv0 = 1'b0; dv1 = 1'b0; din0 = 8'h00; din1 = 4'h0;
    exp0 = 8'b1011_0101;
    exp1 = 8'b1111_0011;  // bits 1,1,0,0 then idle level 1
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lit_x0", x0, exp0[7-i]);
      chk("lit_last0", last0, i == 7);
      chk("lit_x1", x1, exp1[i]);
      chk("lit_xv1", xv1, i < 4);
    end
    @(negedge clk);
    chk("lit_end_xv0", xv0, 1'b0);

    // Back-to-back A5 then 3C with valid held: 16 contiguous valid cycles.
    @(posedge clk); #1;
    din0 = 8'hA5; dv0 = 1'b1;
    tick();
    din0 = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("b2b_xv0", xv0, 1'b1);
      chk("b2b_rdy0", rdy0, i == 7 || i == 15);
      if (i == 7) begin
        @(posedge clk); #1;
        dv0 = 1'b0;
      end
    end
    tick();
    tick();

    // Reset while bit 3 of 8'hFF is on x; then 8'h01 goes through cleanly.
    din0 = 8'hFF; dv0 = 1'b1;
    tick();
    dv0 = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("pre_rst_xv0", xv0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; dv0 = 1'b1;
    tick();
    rst = 1'b0; dv0 = 1'b0;
    @(negedge clk);
    chk("rst_xv0", xv0, 1'b0);
    chk("rst_x0", x0, 1'b0);
    chk("rst_last0", last0, 1'b0);
    chk("rst_rdy0", rdy0, 1'b1);
    @(posedge clk); #1;
    din0 = 8'h01; dv0 = 1'b1;
    tick();
    dv0 = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Random traffic with occasional resets and din churn while busy.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      dv0  = ($urandom_range(0, 3) != 0);
      dv1  = ($urandom_range(0, 2) != 0);
      din0 = 8'($urandom);
      din1 = 4'($urandom);
      tick();
    end
    rst = 1'b0; dv0 = 1'b0; dv1 = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
